// File: rtl/mfcc_pkg.sv
// Shared constants, FSM state encoding and boundary-ROM field helpers for the
// mel filterbank stage of the MFCC front end.
package mfcc_pkg;

    localparam int NUM_BINS    = 128;
    localparam int NUM_FILTERS = 40;
    localparam int DATA_W      = 32;
    localparam int COEF_W      = 16;
    localparam int ACC_W       = 48;
    localparam int WADDR_W     = 10;

    localparam int BIN_W   = $clog2(NUM_BINS + 1);
    localparam int BADDR_W = $clog2(NUM_BINS);
    localparam int FILT_W  = $clog2(NUM_FILTERS);
    localparam int BND_W   = 2 * BIN_W;

    // Boundary entry layout: {start_bin, width}
    localparam int BND_START_LSB = BIN_W;
    localparam int BND_WIDTH_LSB = 0;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_BOUNDS = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUTPUT = 3'd4
    } state_e;

    function automatic logic [BIN_W-1:0] bnd_start(input logic [BND_W-1:0] e);
        return e[BND_START_LSB +: BIN_W];
    endfunction

    function automatic logic [BIN_W-1:0] bnd_width(input logic [BND_W-1:0] e);
        return e[BND_WIDTH_LSB +: BIN_W];
    endfunction

endpackage

// File: rtl/mel_mac_sat.sv
// Two-stage registered multiply with saturating accumulate. Operands arrive one
// cycle after issue (buffer read and weight ROM latency); the full-width product
// is registered, then added into the accumulator, which clamps at all-ones.
module mel_mac_sat
    import mfcc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              issue_i,
    input  logic              clip_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [COEF_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic [ACC_W-1:0]  acc_next_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0]  acc,
                                                 input logic [PROD_W-1:0] prod);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W+1)'(prod);
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    logic              vld_p1_q, vld_p1_d;
    logic              vld_p2_q, vld_p2_d;
    logic [PROD_W-1:0] prod_p2_q, prod_p2_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    // Pipeline advance and accumulator next value; clipped bins never become valid
    always_comb begin
        vld_p1_d  = issue_i & ~clip_i;
        vld_p2_d  = vld_p1_q;
        prod_p2_d = {{COEF_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
        acc_d     = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (vld_p2_q) begin
            acc_d = sat_add(acc_q, prod_p2_q);
        end
    end

    // Control and accumulator state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            acc_q    <= acc_d;
        end
    end

    // Product register (data only, qualified by vld_p2_q)
    always_ff @(posedge clk) begin
        prod_p2_q <= prod_p2_d;
    end

    assign acc_o      = acc_q;
    assign acc_next_o = acc_d;

endmodule

// File: rtl/mel_fbank_sequencer.sv
// Mel filterbank frame sequencer: buffers one power-spectrum frame, then walks
// the boundary ROM filter by filter, driving a sparse MAC over the bin buffer
// and the weight ROM, and streams one energy per filter downstream.
module mel_fbank_sequencer
    import mfcc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [FILT_W-1:0]  bnd_addr,
    input  logic [BND_W-1:0]   bnd_data,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [COEF_W-1:0]  w_data,
    output logic [ACC_W-1:0]   m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic               frame_err
);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
    logic [FILT_W-1:0]  filt_q, filt_d;
    logic [WADDR_W-1:0] woff_q, woff_d;
    logic [BIN_W-1:0]   k_q, k_d;
    logic [BIN_W-1:0]   start_q, start_d;
    logic [BIN_W-1:0]   width_q, width_d;
    logic               bnd_ph_q, bnd_ph_d;
    logic               drn_ph_q, drn_ph_d;
    logic [ACC_W-1:0]   m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;
    logic               frame_err_q, frame_err_d;

    logic [DATA_W-1:0]  buf_q [NUM_BINS];
    logic [DATA_W-1:0]  rd_data_q;

    logic               wr_en;
    logic [BADDR_W-1:0] wr_addr;
    logic [BIN_W:0]     rd_pos;
    logic [BADDR_W-1:0] rd_addr;
    logic               clip;
    logic               issue;
    logic               acc_clr;
    logic [ACC_W-1:0]   acc_cur;
    logic [ACC_W-1:0]   acc_next;

    // Buffer and weight addressing; bins past the end of the spectrum are clipped
    always_comb begin
        wr_en   = (state_q == ST_LOAD) && s_valid;
        wr_addr = bin_cnt_q[BADDR_W-1:0];
        rd_pos  = {1'b0, start_q} + {1'b0, k_q};
        clip    = rd_pos >= (BIN_W+1)'(NUM_BINS);
        rd_addr = rd_pos[BADDR_W-1:0];
        issue   = (state_q == ST_ACCUM);
    end

    // Spectrum buffer write port and registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_addr] <= s_data;
        end
        rd_data_q <= buf_q[rd_addr];
    end

    mel_mac_sat u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (acc_clr),
        .issue_i    (issue),
        .clip_i     (clip),
        .a_i        (rd_data_q),
        .b_i        (w_data),
        .acc_o      (acc_cur),
        .acc_next_o (acc_next)
    );

    // Next-state, counters and output register values
    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        filt_d      = filt_q;
        woff_d      = woff_q;
        k_d         = k_q;
        start_d     = start_q;
        width_d     = width_q;
        bnd_ph_d    = bnd_ph_q;
        drn_ph_d    = drn_ph_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_err_d = 1'b0;
        acc_clr     = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (s_valid) begin
                    if (bin_cnt_q == BIN_W'(NUM_BINS - 1)) begin
                        // A full frame is processed even when s_last is missing
                        bin_cnt_d   = '0;
                        filt_d      = '0;
                        woff_d      = '0;
                        bnd_ph_d    = 1'b0;
                        frame_err_d = ~s_last;
                        state_d     = ST_BOUNDS;
                    end else if (s_last) begin
                        frame_err_d = 1'b1;
                        bin_cnt_d   = '0;
                    end else begin
                        bin_cnt_d = bin_cnt_q + BIN_W'(1);
                    end
                end
            end
            ST_BOUNDS: begin
                acc_clr = 1'b1;
                if (!bnd_ph_q) begin
                    bnd_ph_d = 1'b1;
                end else begin
                    bnd_ph_d = 1'b0;
                    start_d  = bnd_start(bnd_data);
                    width_d  = bnd_width(bnd_data);
                    k_d      = '0;
                    drn_ph_d = 1'b0;
                    state_d  = (bnd_width(bnd_data) == '0) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (k_q == width_q - BIN_W'(1)) begin
                    woff_d   = woff_q + WADDR_W'(width_q);
                    k_d      = '0;
                    drn_ph_d = 1'b0;
                    state_d  = ST_DRAIN;
                end else begin
                    k_d = k_q + BIN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!drn_ph_q) begin
                    drn_ph_d = 1'b1;
                end else begin
                    // Last product lands in the accumulator on this edge
                    drn_ph_d  = 1'b0;
                    m_data_d  = acc_next;
                    m_valid_d = 1'b1;
                    m_last_d  = (filt_q == FILT_W'(NUM_FILTERS - 1));
                    state_d   = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    bnd_ph_d  = 1'b0;
                    if (m_last_q) begin
                        filt_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        filt_d  = filt_q + FILT_W'(1);
                        state_d = ST_BOUNDS;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            bin_cnt_q   <= '0;
            filt_q      <= '0;
            woff_q      <= '0;
            k_q         <= '0;
            start_q     <= '0;
            width_q     <= '0;
            bnd_ph_q    <= 1'b0;
            drn_ph_q    <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            filt_q      <= filt_d;
            woff_q      <= woff_d;
            k_q         <= k_d;
            start_q     <= start_d;
            width_q     <= width_d;
            bnd_ph_q    <= bnd_ph_d;
            drn_ph_q    <= drn_ph_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s_ready   = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_LOAD);
    assign bnd_addr  = filt_q;
    assign w_addr    = woff_q + WADDR_W'(k_q);
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign frame_err = frame_err_q;

    // Running accumulator is only observed through m_data
    logic unused_acc;
    assign unused_acc = ^acc_cur;

endmodule

// File: tb/tb_mel_fbank_sequencer.sv
// Directed self-checking bench for mel_fbank_sequencer with ROM models.
module tb_mel_fbank_sequencer;
    import mfcc_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DATA_W-1:0]  s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic [FILT_W-1:0]  bnd_addr;
    logic [BND_W-1:0]   bnd_data;
    logic [WADDR_W-1:0] w_addr;
    logic [COEF_W-1:0]  w_data;
    logic [ACC_W-1:0]   m_data;
    logic               m_valid;
    logic               m_last;
    logic               m_ready;
    logic               busy;
    logic               frame_err;

    mel_fbank_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .bnd_addr  (bnd_addr),
        .bnd_data  (bnd_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    logic [BND_W-1:0]  bnd_rom [NUM_FILTERS];
    logic [COEF_W-1:0] w_rom   [0:(1<<WADDR_W)-1];

    always @(posedge clk) begin
        bnd_data <= bnd_rom[bnd_addr];
        w_data   <= w_rom[w_addr];
    end

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int hs_cnt = 0;

    always @(posedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (m_valid && m_ready) hs_cnt <= hs_cnt + 1;
    end

    logic [ACC_W-1:0] energy [NUM_FILTERS];
    logic             lastf  [NUM_FILTERS];
    int               n_got;
    int               first_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int p, input int i);
        case (p)
            0:       return DATA_W'(1);
            1:       return DATA_W'(i);
            default: return '1;
        endcase
    endfunction

    task automatic clear_roms();
        for (int f = 0; f < NUM_FILTERS; f++) bnd_rom[f] = '0;
        for (int a = 0; a < (1<<WADDR_W); a++) w_rom[a] = '0;
    endtask

    task automatic set_bnd(input int f, input int st, input int w);
        bnd_rom[f] = {BIN_W'(st), BIN_W'(w)};
    endtask

    task automatic send_frame(input int p, input int nbeats, input int last_idx);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = pat(p, i);
            s_last  = (i == last_idx);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic collect(input int budget);
        n_got     = 0;
        first_cyc = -1;
        m_ready   = 1'b1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            energy[i] = '0;
            lastf[i]  = 1'b0;
        end
        for (int c = 0; c < budget && n_got < NUM_FILTERS; c++) begin
            if (m_valid) begin
                if (first_cyc < 0) first_cyc = c;
                energy[n_got] = m_data;
                lastf[n_got]  = m_last;
                n_got++;
            end
            @(negedge clk);
        end
        check("collect_count", 64'(n_got), 64'(NUM_FILTERS));
    endtask

    task automatic check_last(input string tag);
        int cnt;
        int pos;
        cnt = 0;
        pos = -1;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (lastf[i]) begin
                cnt++;
                pos = i;
            end
        end
        check({tag, "_last_cnt"}, 64'(cnt), 64'd1);
        check({tag, "_last_pos"}, 64'(pos), 64'(NUM_FILTERS - 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr0;
        int hs0;
        int nz;
        int seen;
        int stable;
        logic [ACC_W-1:0] held;

        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        clear_roms();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_s_ready",   64'(s_ready),   64'd1);
        check("rst_m_valid",   64'(m_valid),   64'd0);
        check("rst_m_last",    64'(m_last),    64'd0);
        check("rst_m_data",    64'(m_data),    64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_bnd_addr",  64'(bnd_addr),  64'd0);
        check("rst_w_addr",    64'(w_addr),    64'd0);

        // All-ones spectrum, filter 0 {0,4} with 0x8000 weights: 4 * 32768
        clear_roms();
        set_bnd(0, 0, 4);
        for (int a = 0; a < 4; a++) w_rom[a] = 16'h8000;
        send_frame(0, 128, 127);
        check("t2_busy",    64'(busy),    64'd1);
        check("t2_s_ready", 64'(s_ready), 64'd0);
        collect(5000);
        check("t2_latency", 64'(first_cyc), 64'd8);
        check("t2_e0",      64'(energy[0]), 64'd131072);
        nz = 0;
        for (int i = 1; i < NUM_FILTERS; i++) if (energy[i] != '0) nz++;
        check("t2_zeros", 64'(nz), 64'd0);
        check_last("t2");
        check("t2_woff",     64'(w_addr),  64'd4);
        check("t2_s_ready2", 64'(s_ready), 64'd1);

        // Ramp spectrum: filter 0 {0,2} w=5,7 -> 7; filter 3 {10,3} w=1,2,3 -> 68
        clear_roms();
        set_bnd(0, 0, 2);
        w_rom[0] = 16'd5;
        w_rom[1] = 16'd7;
        set_bnd(3, 10, 3);
        w_rom[2] = 16'd1;
        w_rom[3] = 16'd2;
        w_rom[4] = 16'd3;
        send_frame(1, 128, 127);
        collect(5000);
        check("t3_e0", 64'(energy[0]), 64'd7);
        check("t3_e1", 64'(energy[1]), 64'd0);
        check("t3_e3", 64'(energy[3]), 64'd68);
        check_last("t3");

        // Early s_last on beat 50 discards the frame; the next frame is clean
        ferr0 = ferr_cnt;
        hs0   = hs_cnt;
        send_frame(2, 51, 50);
        repeat (20) @(negedge clk);
        check("t5_ferr_pulse", 64'(ferr_cnt - ferr0), 64'd1);
        check("t5_no_valid",   64'(hs_cnt - hs0),     64'd0);
        check("t5_s_ready",    64'(s_ready),          64'd1);
        check("t5_busy",       64'(busy),             64'd0);
        send_frame(1, 128, 127);
        collect(5000);
        check("t5_e0",   64'(energy[0]), 64'd7);
        check("t5_e3",   64'(energy[3]), 64'd68);
        check("t5_ferr", 64'(ferr_cnt - ferr0), 64'd1);

        // Saturation and full-width product
        clear_roms();
        set_bnd(0, 0, 128);
        for (int a = 0; a < 128; a++) w_rom[a] = 16'hFFFF;
        set_bnd(1, 0, 1);
        w_rom[128] = 16'hFFFF;
        set_bnd(2, 0, 2);
        w_rom[129] = 16'hFFFF;
        w_rom[130] = 16'h0001;
        send_frame(2, 128, 127);
        collect(5000);
        check("t4_sat", 64'(energy[0]), 64'h0000_FFFF_FFFF_FFFF);
        check("t4_e1",  64'(energy[1]), 64'h0000_FFFE_FFFF_0001);
        check("t4_e2",  64'(energy[2]), 64'h0000_FFFF_FFFF_0000);
        check("t4_e3",  64'(energy[3]), 64'd0);

        // Clipped filter {120,16}, woff advances by 16, backpressure, missing s_last
        clear_roms();
        set_bnd(0, 120, 16);
        for (int a = 0; a < 16; a++) w_rom[a] = 16'd1;
        set_bnd(1, 5, 1);
        w_rom[16] = 16'd3;
        ferr0   = ferr_cnt;
        m_ready = 1'b0;
        send_frame(1, 128, -1);
        seen = 0;
        for (int c = 0; c < 500 && seen == 0; c++) begin
            if (m_valid) seen = 1;
            else @(negedge clk);
        end
        check("t6_valid_seen", 64'(seen), 64'd1);
        held   = m_data;
        stable = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!(m_valid === 1'b1 && m_data === held && s_ready === 1'b0)) stable = 0;
        end
        check("t6_bp_stable", 64'(stable), 64'd1);
        check("t6_bp_e0",     64'(held),   64'd988);
        collect(5000);
        check("t6_e0",   64'(energy[0]), 64'd988);
        check("t6_e1",   64'(energy[1]), 64'd15);
        check("t6_ferr", 64'(ferr_cnt - ferr0), 64'd1);

        // Reset during ACCUM of filter 5, then a fresh frame
        clear_roms();
        set_bnd(0, 0, 2);
        w_rom[0] = 16'd5;
        w_rom[1] = 16'd7;
        set_bnd(3, 10, 3);
        w_rom[2] = 16'd1;
        w_rom[3] = 16'd2;
        w_rom[4] = 16'd3;
        set_bnd(5, 0, 100);
        for (int a = 5; a < 105; a++) w_rom[a] = 16'd1;
        send_frame(1, 128, 127);
        m_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 2000 && seen == 0; c++) begin
            if (bnd_addr == FILT_W'(5)) seen = 1;
            else @(negedge clk);
        end
        check("t7_filt5_seen", 64'(seen), 64'd1);
        repeat (10) @(negedge clk);
        check("t7_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_m_valid",  64'(m_valid),  64'd0);
        check("t7_s_ready",  64'(s_ready),  64'd1);
        check("t7_busy",     64'(busy),     64'd0);
        check("t7_bnd_addr", 64'(bnd_addr), 64'd0);
        check("t7_w_addr",   64'(w_addr),   64'd0);
        check("t7_m_data",   64'(m_data),   64'd0);
        send_frame(1, 128, 127);
        collect(5000);
        check("t7_e0", 64'(energy[0]), 64'd7);
        check("t7_e3", 64'(energy[3]), 64'd68);
        check("t7_e5", 64'(energy[5]), 64'd4950);
        check_last("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
